// File: rtl/display_scan_ctrl_if.sv
// Display scan controller bus: value/control from the producer,
// segment and anode pins plus status pulses back from the controller.
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
) ();
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic                    blank_lz;
  logic [3:0]              brightness;
  logic [7:0]              segments;
  logic [NUM_DIGITS-1:0]   digit_sel;
  logic                    frame_tick;
  logic                    applied;

  modport master (
    output enable, load, value, dp_mask, blank_lz, brightness,
    input  segments, digit_sel, frame_tick, applied
  );

  modport slave (
    input  enable, load, value, dp_mask, blank_lz, brightness,
    output segments, digit_sel, frame_tick, applied
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scanner with double-buffered data,
// leading-zero blanking and 16-level per-slot PWM brightness.
module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SUB_DIV    = 3125
) (
  input logic                clk,
  input logic                reset,
  display_scan_ctrl_if.slave bus
);
  localparam int PW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         presc;
  logic [3:0]            phase;
  logic [IW-1:0]         idx;
  logic [VW-1:0]         act_val;
  logic [VW-1:0]         pend_val;
  logic [NUM_DIGITS-1:0] act_dp;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pend_valid;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic                  tick_q;
  logic                  app_q;

  logic                  presc_tc;
  logic                  phase_tc;
  logic                  idx_tc;
  logic                  frame_end;
  logic [3:0]            nib;
  logic [6:0]            pat;
  logic [NUM_DIGITS:0]   zrun;
  logic                  blank;
  logic [7:0]            seg_nx;
  logic [NUM_DIGITS-1:0] sel_nx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign presc_tc  = presc == PW'(SUB_DIV - 1);
  assign phase_tc  = phase == 4'hF;
  assign idx_tc    = idx == IW'(NUM_DIGITS - 1);
  assign frame_end = presc_tc && phase_tc && idx_tc;

  // zrun[i]: digits NUM_DIGITS-1 down to i are all zero with no dp
  always_comb begin
    zrun = '0;
    zrun[NUM_DIGITS] = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zrun[i] = zrun[i+1] && (act_val[4*i +: 4] == 4'h0) && !act_dp[i];
    end
  end

  always_comb begin
    nib    = act_val[idx*4 +: 4];
    pat    = hex7(nib);
    blank  = bus.blank_lz && (idx != '0) && zrun[idx];
    seg_nx = blank ? 8'hFF : {~act_dp[idx], pat};
    sel_nx = '1;
    if (bus.enable && (phase < bus.brightness)) begin
      sel_nx[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      phase      <= '0;
      idx        <= '0;
      act_val    <= '0;
      act_dp     <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      seg_q      <= 8'hFF;
      sel_q      <= '1;
      tick_q     <= 1'b0;
      app_q      <= 1'b0;
    end else begin
      tick_q <= frame_end;
      app_q  <= 1'b0;
      presc  <= presc_tc ? '0 : presc + 1'b1;
      if (presc_tc) begin
        phase <= phase + 4'd1;
        if (phase_tc) begin
          idx <= idx_tc ? '0 : idx + 1'b1;
        end
      end
      // a load landing on the boundary bypasses the pending buffer
      if (frame_end && bus.load) begin
        act_val    <= bus.value;
        act_dp     <= bus.dp_mask;
        pend_valid <= 1'b0;
        app_q      <= 1'b1;
      end else if (frame_end && pend_valid) begin
        act_val    <= pend_val;
        act_dp     <= pend_dp;
        pend_valid <= 1'b0;
        app_q      <= 1'b1;
      end else if (bus.load) begin
        pend_val   <= bus.value;
        pend_dp    <= bus.dp_mask;
        pend_valid <= 1'b1;
      end
      seg_q <= seg_nx;
      sel_q <= sel_nx;
    end
  end

  assign bus.segments   = seg_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_tick = tick_q;
  assign bus.applied    = app_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: reset, frame timing,
// buffering, decode, blanking and brightness on a small scan.
module tb_display_scan_ctrl;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  display_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS(4),
    .SUB_DIV   (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one 128-cycle frame starting right after a frame_tick sample.
  // Loads are driven while the counters hold state la / lb.
  task automatic scan(input string tag, input logic [31:0] segs,
                      input int low, input int napp,
                      input int la, input logic [15:0] lv,
                      input logic [3:0] ld,
                      input int lb, input logic [15:0] lv2,
                      input logic [3:0] ld2);
    int         lowc[4];
    int         segbad[4];
    logic [7:0] first[4];
    int         bad;
    int         ticks;
    int         appc;
    logic       app_last;
    logic       tick_last;
    int         d;
    logic [7:0] es;
    logic [3:0] esel;
    bad = 0;
    ticks = 0;
    appc = 0;
    app_last = 1'b0;
    tick_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      lowc[k] = 0;
      segbad[k] = 0;
      first[k] = 8'h00;
    end
    for (int j = 0; j < 128; j++) begin
      if (j == la) begin
        bus.load = 1'b1;
        bus.value = lv;
        bus.dp_mask = ld;
      end else if (j == lb) begin
        bus.load = 1'b1;
        bus.value = lv2;
        bus.dp_mask = ld2;
      end else begin
        bus.load = 1'b0;
      end
      @(posedge clk);
      #1;
      d = j / 32;
      es = segs[8*d +: 8];
      esel = ~(4'b0001 << d);
      if (j % 32 == 0) first[d] = bus.segments;
      if (bus.segments !== es) segbad[d]++;
      if (bus.digit_sel === esel) lowc[d]++;
      else if (bus.digit_sel !== 4'hF) bad++;
      if (bus.applied === 1'b1) appc++;
      if (j < 127 && bus.frame_tick !== 1'b0) ticks++;
      if (j == 127) begin
        app_last = bus.applied;
        tick_last = bus.frame_tick;
      end
    end
    bus.load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_d%0d_seg", tag, k), 32'(first[k]),
            32'(segs[8*k +: 8]));
      check($sformatf("%s_d%0d_segerr", tag, k), segbad[k], 0);
      check($sformatf("%s_d%0d_low", tag, k), lowc[k], low);
    end
    check($sformatf("%s_selbad", tag), bad, 0);
    check($sformatf("%s_midtick", tag), ticks, 0);
    check($sformatf("%s_tick128", tag), 32'(tick_last), 1);
    check($sformatf("%s_appcnt", tag), appc, napp);
    check($sformatf("%s_applast", tag), 32'(app_last), napp);
  endtask

  initial begin
    int cyc;
    n_chk = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.enable = 1'b1;
    bus.load = 1'b0;
    bus.value = '0;
    bus.dp_mask = '0;
    bus.blank_lz = 1'b0;
    bus.brightness = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rst%0d_seg", k), 32'(bus.segments), 32'hFF);
      check($sformatf("rst%0d_sel", k), 32'(bus.digit_sel), 32'hF);
      check($sformatf("rst%0d_tick", k), 32'(bus.frame_tick), 0);
      check($sformatf("rst%0d_app", k), 32'(bus.applied), 0);
    end
    reset = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_tick === 1'b1) begin
        cyc = k;
        break;
      end
    end
    check("first_tick", cyc, 128);

    scan("fa", 32'hC0C0C0C0, 30, 1, 0, 16'h12AF, 4'h0,
         -1, 16'h0, 4'h0);
    scan("fb", 32'hF9A4888E, 30, 0, -1, 16'h0, 4'h0,
         -1, 16'h0, 4'h0);
    bus.blank_lz = 1'b1;
    scan("fc", 32'hF9A4888E, 30, 1, 0, 16'h0007, 4'h0,
         -1, 16'h0, 4'h0);
    scan("fd", 32'hFFFFFFF8, 30, 1, 5, 16'h0007, 4'b0100,
         -1, 16'h0, 4'h0);
    scan("fe", 32'hFF40C0F8, 30, 1, 10, 16'h1111, 4'h0,
         60, 16'h2222, 4'h0);
    scan("ff", 32'hA4A4A4A4, 30, 1, 127, 16'h4567, 4'h0,
         -1, 16'h0, 4'h0);
    bus.brightness = 4'd4;
    scan("fg", 32'h999282F8, 8, 0, -1, 16'h0, 4'h0,
         -1, 16'h0, 4'h0);
    bus.brightness = 4'd0;
    scan("fh", 32'h999282F8, 0, 0, -1, 16'h0, 4'h0,
         -1, 16'h0, 4'h0);
    bus.brightness = 4'd15;
    bus.enable = 1'b0;
    scan("fi", 32'h999282F8, 0, 0, -1, 16'h0, 4'h0,
         -1, 16'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
Time-multiplexes a shared hex-to-seven-segment decode across NUM_DIGITS common-anode digits, scanning one digit per slot.
Provides tear-free double-buffered value loading, per-digit decimal points, leading-zero blanking and 16-level PWM brightness.
Sits between the register or datapath that produces display values and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 4, number of scanned digits (2..8)
SUB_DIV, 3125, clock cycles per PWM phase; one digit slot = 16*SUB_DIV cycles

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = display on; 0 = all anodes off (scanning continues)
load  in  1  single-cycle strobe; captures value/dp_mask
value  in  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 = rightmost
dp_mask  in  NUM_DIGITS  1 = light the decimal point of digit i
blank_lz  in  1  1 = suppress leading zeros
brightness  in  4  on-phases per slot; 0 = dark, 15 = 15/16 duty
segments  out  8  active-low; bit7 = dp, bits6..0 = g..a
digit_sel  out  NUM_DIGITS  active-low anode enables, one-hot-low or all high
frame_tick  out  1  one-cycle pulse at each frame start
applied  out  1  one-cycle pulse when pending data becomes active

Behaviour:
- Reset (sync, highest priority, any time, including mid-slot):
  - digit_sel = all 1s, segments = 8'hFF, frame_tick = 0, applied = 0.
  - Prescaler, phase and digit index = 0.
  - Active and pending registers = 0; pending_valid = 0.
- Counters:
  - Prescaler counts 0..SUB_DIV-1; at its terminal count it wraps and phase (4 bit) increments.
  - When phase wraps 15->0, digit index increments 0..NUM_DIGITS-1 and then wraps to 0.
- Frame boundary: the cycle where prescaler, phase and index all wrap to 0.
  - frame_tick is 1 for exactly the following cycle.
- Load/buffer:
  - load=1 copies value and dp_mask into pending and sets pending_valid; repeated loads overwrite pending.
  - At a frame boundary with pending_valid=1, pending is copied to active, pending_valid clears, and applied pulses on the next cycle.
  - If load and a frame boundary coincide, the load data goes directly to active and pending_valid stays 0; applied still pulses.
  - Active data never changes mid-frame.
- Decode (active-low, bit7 clear only when dp lit), nibble 0..F:
  C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E.
- Leading-zero blank:
  - Digit i (i >= 1) is blanked when blank_lz=1 and, for every digit from NUM_DIGITS-1 down to i, the nibble is 0 and its dp is 0.
  - Digit 0 is never suppressed.
  - A blanked digit drives segments = FF.
- Anode drive:
  - digit_sel[index] = 0 only when enable=1 and phase < brightness; otherwise all 1s.
  - When all anodes are off, segments still shows the current digit's pattern.
- Latency: segments and digit_sel are registered. They reflect the counter state one cycle later.
  - An index change appears on digit_sel and segments in the same cycle, so the anode and pattern never mismatch.
- Width rules:
  - brightness compares unsigned against phase.
  - value nibble i = value[4i+3:4i].

Test Plan:
- SUB_DIV=2, NUM_DIGITS=4; reset held for 3 cycles mid-scan -> segments=FF, digit_sel=1111, frame_tick=0 the cycle after reset; first frame_tick 128 cycles after reset release.
- load value=16'h12AF, dp_mask=0, brightness=15, enable=1 -> after the next frame boundary, applied pulses once; per slot: digit0 8E/1110, digit1 88/1101, digit2 A4/1011, digit3 F9/0111; each anode low for 30 of 32 cycles.
- value=16'h0007, blank_lz=1 -> digits 3..1 show FF, digit0 shows F8; with dp_mask=4'b0100 -> digit2 shows 40 (zero with dp), digit3 shows FF, digit1 shows C0.
- Two loads in one frame (16'h1111 then 16'h2222) -> no change mid-frame; next frame shows only 2222; one applied pulse.
- load coinciding exactly with a frame boundary -> new data is displayed in that frame; applied pulses the next cycle.
- brightness=0 or enable=0 -> digit_sel stays 1111 throughout; brightness=4 -> each anode low for exactly 8 cycles per 32-cycle slot; frame_tick period unchanged (128).
